j_ldseq6: RTL
=============

Name: j_ldseq6

Overview:
- Writer-side companion to the 6-bit load-enabled holding register (fd2e-based sync register).
- Accepts 6-bit words from a producer over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Drives the register's d/ld pair with single-cycle ld strobes and enforces a minimum gap between loads.
- Reads the register's q back one cycle after each load and flags any mismatch; used in Jerry wherever a control field is written to a duplicated sync register.

Parameters:
- LD_GAP, 1: idle cycles forced after each VERIFY cycle before the next load (0..15).
- SKIP_SAME, 0: when 1, a word equal to the last value loaded is popped without issuing ld.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  asynchronous active-high reset.
- in_data  in  6  word to load; bit order [0:5], matching the holding register.
- in_valid  in  1  producer has a word on in_data.
- in_ready  out  1  block accepts a word this cycle.
- d  out  6  data to the holding register's d[0:5].
- ld  out  1  load strobe to the holding register.
- q  in  6  readback from the holding register's q[0:5].
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- err  out  1  sticky readback-mismatch flag.
- err_cnt  out  4  saturating mismatch count.
- err_clr  in  1  synchronous clear of err and err_cnt.

Behaviour:
- Reset (async, immediate): FIFO empty, state IDLE, d=0, ld=0, err=0, err_cnt=0, last_valid=0, gap counter=0. All outputs are registered except in_ready and busy.
- in_ready = !full, using registered occupancy. A pop in the same cycle does not open a slot, so there is no push while full.
- Push on in_valid & in_ready. FIFO order is strict first-in, first-out.
- IDLE:
  - FIFO empty: stay.
  - FIFO non-empty and SKIP_SAME=1, last_valid=1, head==last_d: pop and stay in IDLE. No ld.
  - Otherwise: go to LOAD.
- LOAD (one cycle): ld=1, d=head (registered, so both change together), pop head, last_d<=head, last_valid<=1. Next state is VERIFY.
- VERIFY (one cycle): ld=0, d held. Compare q with d.
  - Mismatch: err<=1 and err_cnt<=err_cnt+1, saturating at 15.
  - Next state: GAP if LD_GAP>0, else IDLE.
- GAP: wait LD_GAP cycles, then go to IDLE.
- Throughput: one load per 2+LD_GAP cycles, or 2 cycles when LD_GAP=0.
- Latency: a word pushed into an empty FIFO while the FSM is in IDLE has ld asserted 2 cycles after the push edge (IDLE decision, then LOAD).
- d holds the last loaded value at all times outside LOAD. ld is never asserted on two consecutive cycles.
- err_clr has priority over a same-cycle mismatch: the result is err=0, err_cnt=0.
- busy = (state != IDLE) | !empty.
- rst asserted mid-LOAD drops ld immediately. The pending FIFO words are discarded and no VERIFY follows.

Decomposition:
- Package j_ldseq_pkg:
  - state enum {IDLE, LOAD, VERIFY, GAP}.
  - constant LDSEQ_W=6.
  - constant ERRCNT_W=4.
- Sub-module j_ldseq_fifo2: 2-entry FIFO with full/empty flags, push, pop and head output, plus async active-high reset.
- FSM, gap counter and checker live in the top module.

Test Plan:
- Reset with a word on in_data: after rst release, in_ready=1, ld=0, d=0. Push 0x2A: ld=1 and d=0x2A exactly 2 cycles later. A q model loading 0x2A gives err=0.
- Back-to-back pushes 0x01, 0x02, 0x03 with LD_GAP=1:
  - in_ready drops after the 2nd push.
  - ld pulses are spaced exactly 3 cycles apart, with d=0x01, 0x02, 0x03 in order.
  - No word is lost.
- Faulty register model returning q=0x00 after loading 0x15: err=1 and err_cnt=1 at the cycle after VERIFY. 17 more faults saturate err_cnt at 15. err_clr clears both.
- SKIP_SAME=1, push 0x3F, 0x3F, 0x10: exactly two ld pulses (0x3F, 0x10). The duplicate is popped silently and busy returns to 0.
- Assert rst during a LOAD cycle with 1 word queued: ld drops within the same cycle. After release the FIFO is empty, busy=0, and no further ld occurs.
- LD_GAP=0 with a continuous stream: ld on every other cycle. Simultaneous pop-while-full causes no push in that cycle.

Source files
------------

// File: rtl/j_ldseq_pkg.sv
// rtl/j_ldseq_pkg.sv - shared types and widths for the load sequencer
package j_ldseq_pkg;
  localparam int LDSEQ_W  = 6;
  localparam int ERRCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    VERIFY,
    GAP
  } state_t;
endpackage

// File: rtl/j_ldseq_fifo2.sv
// rtl/j_ldseq_fifo2.sv - two-entry first-in first-out word buffer
module j_ldseq_fifo2 import j_ldseq_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [0:LDSEQ_W-1] wdata,
  input  logic               pop,
  output logic [0:LDSEQ_W-1] head,
  output logic               full,
  output logic               empty
);
  logic [0:LDSEQ_W-1] mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               do_push;
  logic               do_pop;

  // A push into a full buffer is dropped even if a pop happens the same cycle
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      if (do_push && !do_pop)      count <= count + 2'd1;
      else if (do_pop && !do_push) count <= count - 2'd1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/j_ldseq6.sv
// rtl/j_ldseq6.sv - writer and readback checker for a 6-bit load-enabled register
module j_ldseq6 import j_ldseq_pkg::*; #(
  parameter int LD_GAP    = 1,
  parameter bit SKIP_SAME = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [0:LDSEQ_W-1]  in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [0:LDSEQ_W-1]  d,
  output logic                ld,
  input  logic [0:LDSEQ_W-1]  q,
  output logic                busy,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_cnt,
  input  logic                err_clr
);
  localparam logic [3:0] GAP_LAST = (LD_GAP > 0) ? 4'(LD_GAP - 1) : 4'd0;

  state_t             state;
  state_t             next_state;
  logic [3:0]         gap_cnt;
  logic [0:LDSEQ_W-1] head;
  logic [0:LDSEQ_W-1] last_d;
  logic               last_valid;
  logic               full;
  logic               empty;
  logic               pop;
  logic               load_go;
  logic               decide;
  logic               skip_hit;

  j_ldseq_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid & in_ready),
    .wdata (in_data),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign in_ready = ~full;
  assign busy     = (state != IDLE) | ~empty;
  assign skip_hit = SKIP_SAME & last_valid & (head == last_d);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state; the idle dispatch rule is also applied on the last wait cycle
  // so a queued word loads without an extra idle cycle between loads
  always_comb begin
    next_state = state;
    decide     = 1'b0;
    pop        = 1'b0;
    load_go    = 1'b0;
    case (state)
      IDLE:    decide = 1'b1;
      LOAD:    begin
        pop        = 1'b1;
        next_state = VERIFY;
      end
      VERIFY:  if (LD_GAP == 0) decide = 1'b1; else next_state = GAP;
      GAP:     if (gap_cnt == GAP_LAST) decide = 1'b1;
      default: next_state = IDLE;
    endcase
    if (decide) begin
      next_state = IDLE;
      if (!empty) begin
        if (skip_hit) begin
          pop = 1'b1;
        end else begin
          load_go    = 1'b1;
          next_state = LOAD;
        end
      end
    end
  end

  // Gap counter restarts on every VERIFY and runs through GAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  gap_cnt <= 4'd0;
    else if (state == VERIFY) gap_cnt <= 4'd0;
    else if (state == GAP)    gap_cnt <= gap_cnt + 4'd1;
  end

  // Register drive: ld and d change together on the edge entering LOAD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld         <= 1'b0;
      d          <= '0;
      last_d     <= '0;
      last_valid <= 1'b0;
    end else begin
      ld <= load_go;
      if (load_go) begin
        d          <= head;
        last_d     <= head;
        last_valid <= 1'b1;
      end
    end
  end

  // Readback checker; a clear wins over a mismatch in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (err_clr) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (state == VERIFY && q != d) begin
      err <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + 4'd1;
    end
  end
endmodule
